align_out_framer: RTL and testbench
===================================

# align_out_framer

Downstream stage of the local-alignment core. It accepts traceback letters, which the core produces end-to-start, and buffers them in a LIFO so they can be replayed start-to-end. It emits each alignment as a framed 3-bit letter stream: START_OUTPUT, the letters, then END_OUTPUT. The output stream is what the verification environment collects into an out-letter queue per alignment.

## Interface
Parameters:
- DEPTH, 32: maximum letters per alignment (LIFO entries).
- LETTER_WIDTH, 3: letter/marker width; must be 3.

Ports:
- clk, in, 1: single clock, all logic rising-edge.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: traceback letter present.
- in_letter, in, LETTER_WIDTH: 000 A, 001 C, 010 G, 011 T, 100 gap; 101/110/111 illegal.
- in_last, in, 1: qualifies the final traceback letter (the alignment's first position).
- in_ready, out, 1: framer accepts input this cycle.
- out_valid, out, 1: out_letter valid.
- out_letter, out, LETTER_WIDTH: framed stream word.
- out_ready, in, 1: consumer accepts out_letter.
- busy, out, 1: high in every state except FILL-with-empty-stack.
- overflow, out, 1: sticky; letters were dropped in the current alignment.
- illegal, out, 1: sticky; an illegal code was received in the current alignment.

## Operation
- FSM states: FILL, START, DRAIN, END.
- Reset (async, rst_n low) forces:
  - FILL state, empty stack;
  - in_ready=1, out_valid=0, out_letter=000, busy=0, overflow=0, illegal=0.
- FILL:
  - in_ready=1, out_valid=0.
  - A transfer is in_valid && in_ready.
  - A legal letter is pushed if count<DEPTH.
  - If count==DEPTH the letter is dropped and overflow is set.
  - An illegal letter is never pushed and sets illegal. in_last on an illegal letter still ends the alignment.
  - A transfer with in_last=1 moves to START.
- START:
  - in_ready=0; out_valid=1; out_letter=START_OUTPUT (111).
  - On out_ready, go to DRAIN if count>0, else to END.
- DRAIN:
  - out_letter=top of stack. On out_ready, pop.
  - When the popped entry was the last (count==1), go to END.
- END:
  - out_letter=END_OUTPUT (111).
  - On out_ready, go to FILL, clear overflow and illegal, and clear the stack.
- Output handshake: while out_valid && !out_ready, out_letter is held stable. out_valid never drops before acceptance.
- Count register is $clog2(DEPTH+1) bits, saturating at DEPTH. Stack pointer never wraps.
- Simultaneous events: in_valid is ignored in every state except FILL.
- Reset mid-operation discards the partial frame. No END_OUTPUT is emitted.

## Timing
- Registered outputs: out_valid, out_letter, in_ready, busy.
- START word is valid the cycle after the in_last transfer.
- With out_ready held high, a frame of N letters occupies N+2 consecutive output cycles.
- in_ready rises the cycle after END is accepted.
- Throughput: 1 letter/cycle on input, 1 word/cycle on output.
- No combinational path from out_ready to out_letter. The stack read is registered ahead via a top-of-stack register.

## Configuration
- ALIGN_FRAMER_LEN_EN defined:
  - Adds output port out_len, $clog2(DEPTH+1) bits.
  - out_len holds the stored letter count, valid while END_OUTPUT is presented; it is 0 otherwise and at reset.
- Undefined: the port and its logic are absent. Framing behaviour is identical.

## Structure
- Shared package (design_variables) holds:
  - START_OUTPUT and END_OUTPUT (3'b111);
  - the letter-code enum (A, C, G, T, GAP);
  - the framer state enum;
  - the DEPTH default.
- Sub-module align_lifo: DEPTH x LETTER_WIDTH stack with push, pop, clear, count, top, full and empty. The framer owns only the FSM, flags and handshakes.

## Test plan
- Basic frame: push T,G,C,A (A with in_last), out_ready=1. Expect output 111,000,001,010,011,111, in_ready=0 for exactly 6 cycles, then in_ready=1.
- Backpressure: same frame, out_ready toggling 1/0 each cycle. Expect every word held stable while stalled and the same 6-word sequence, with no loss or duplication.
- Overflow: DEPTH=4, push 6 legal letters (6th with in_last). Expect overflow=1, exactly 4 letters between markers (the first 4 pushed, reversed), and overflow=0 after END is accepted.
- Illegal code: push C, 110, G(in_last). Expect illegal=1, output 111,010,001,111.
- Single-letter and length report: push gap (100) with in_last, ALIGN_FRAMER_LEN_EN defined. Expect 111,100,111 and out_len=1 during END.
- Reset mid-DRAIN: assert rst_n=0 after 2 letters are emitted. Expect out_valid=0 immediately, stack empty, and in_ready=1 after release.

Source files
------------

// File: rtl/align_out_framer_pkg.sv
// Shared constants and types for the alignment output framer: stream markers,
// letter codes, framer states and the default stack depth.
package design_variables;

    localparam int          DEPTH_DEFAULT = 32;
    localparam logic [2:0]  START_OUTPUT  = 3'b111;
    localparam logic [2:0]  END_OUTPUT    = 3'b111;

    typedef enum logic [2:0] {
        LETTER_A   = 3'b000,
        LETTER_C   = 3'b001,
        LETTER_G   = 3'b010,
        LETTER_T   = 3'b011,
        LETTER_GAP = 3'b100
    } letter_e;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_START,
        ST_DRAIN,
        ST_END
    } framer_state_e;

    // Codes above GAP are illegal.
    function automatic logic is_legal(input logic [2:0] code);
        return code <= 3'(LETTER_GAP);
    endfunction

endpackage

// File: rtl/align_out_framer_lifo.sv
// align_lifo: DEPTH x WIDTH stack with a registered top-of-stack and a
// look-ahead read of the entry below it, so pops can feed a registered output.
module align_lifo #(
    parameter  int DEPTH = 32,
    parameter  int WIDTH = 3,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_clear,
    output logic [CW-1:0]    o_count,
    output logic [WIDTH-1:0] o_top,
    output logic [WIDTH-1:0] o_below,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_top;
    logic             w_do_push;
    logic             w_do_pop;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_below_idx;

    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign w_do_push   = i_push && !o_full;
    assign w_do_pop    = i_pop && !o_empty;
    assign w_wr_idx    = r_count[AW-1:0];
    assign w_below_idx = (r_count >= CW'(2)) ? AW'(r_count - CW'(2)) : '0;

    assign o_count = r_count;
    assign o_top   = r_top;
    assign o_below = r_mem[w_below_idx];

    // NOTE: storage has no reset; r_count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[w_wr_idx] <= i_data;
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_top   <= '0;
        end else if (i_clear) begin
            r_count <= '0;
            r_top   <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + CW'(1);
            r_top   <= i_data;
        end else if (w_do_pop) begin
            r_count <= r_count - CW'(1);
            r_top   <= (r_count >= CW'(2)) ? r_mem[w_below_idx] : '0;
        end
    end

endmodule

// File: rtl/align_out_framer.sv
// align_out_framer: buffers end-to-start traceback letters in a LIFO and emits
// each alignment as START_OUTPUT, letters start-to-end, END_OUTPUT.
// Optional feature macro ALIGN_FRAMER_LEN_EN adds the out_len port.
module align_out_framer
    import design_variables::*;
#(
    parameter  int DEPTH        = DEPTH_DEFAULT,
    parameter  int LETTER_WIDTH = 3,
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [LETTER_WIDTH-1:0] in_letter,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [LETTER_WIDTH-1:0] out_letter,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    overflow,
    output logic                    illegal
`ifdef ALIGN_FRAMER_LEN_EN
    ,
    output logic [CW-1:0]           out_len
`endif
);

    framer_state_e           r_state;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [LETTER_WIDTH-1:0] r_out_letter;
    logic                    r_busy;
    logic                    r_overflow;
    logic                    r_illegal;

    logic                    w_transfer;
    logic                    w_legal;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_clear;
    logic [CW-1:0]           w_count;
    logic [LETTER_WIDTH-1:0] w_top;
    logic [LETTER_WIDTH-1:0] w_below;
    logic                    w_full;
    logic                    w_empty;

    assign w_transfer = in_valid && r_in_ready;
    assign w_legal    = is_legal(in_letter);
    assign w_push     = w_transfer && w_legal;
    assign w_pop      = (r_state == ST_DRAIN) && out_ready;
    assign w_clear    = (r_state == ST_END) && out_ready;

    align_lifo #(
        .DEPTH (DEPTH),
        .WIDTH (LETTER_WIDTH)
    ) u_lifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (in_letter),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .o_count (w_count),
        .o_top   (w_top),
        .o_below (w_below),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef ALIGN_FRAMER_LEN_EN
    logic [CW-1:0] r_frame_len;
    logic [CW-1:0] r_out_len;
    assign out_len = r_out_len;
`endif

    // Output words are loaded one edge ahead, so out_ready never reaches out_letter combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FILL;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_letter <= '0;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
            r_illegal    <= 1'b0;
`ifdef ALIGN_FRAMER_LEN_EN
            r_frame_len  <= '0;
            r_out_len    <= '0;
`endif
        end else begin
            unique case (r_state)
                ST_FILL: begin
                    if (w_transfer) begin
                        if (!w_legal)    r_illegal  <= 1'b1;
                        else if (w_full) r_overflow <= 1'b1;
                        else             r_busy     <= 1'b1;
                        if (in_last) begin
                            r_state      <= ST_START;
                            r_in_ready   <= 1'b0;
                            r_out_valid  <= 1'b1;
                            r_out_letter <= START_OUTPUT;
                            r_busy       <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    if (out_ready) begin
`ifdef ALIGN_FRAMER_LEN_EN
                        r_frame_len <= w_count;
`endif
                        if (!w_empty) begin
                            r_state      <= ST_DRAIN;
                            r_out_letter <= w_top;
                        end else begin
                            r_state      <= ST_END;
                            r_out_letter <= END_OUTPUT;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (w_count == CW'(1)) begin
                            r_state      <= ST_END;
                            r_out_letter <= END_OUTPUT;
`ifdef ALIGN_FRAMER_LEN_EN
                            r_out_len    <= r_frame_len;
`endif
                        end else begin
                            r_out_letter <= w_below;
                        end
                    end
                end
                ST_END: begin
                    if (out_ready) begin
                        r_state      <= ST_FILL;
                        r_in_ready   <= 1'b1;
                        r_out_valid  <= 1'b0;
                        r_out_letter <= '0;
                        r_busy       <= 1'b0;
                        r_overflow   <= 1'b0;
                        r_illegal    <= 1'b0;
`ifdef ALIGN_FRAMER_LEN_EN
                        r_out_len    <= '0;
`endif
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_letter = r_out_letter;
    assign busy       = r_busy;
    assign overflow   = r_overflow;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_align_out_framer.sv
// Randomized bench for align_out_framer: a queue model derives each expected
// framed word stream and flag values from the letters sent.
module tb_align_out_framer;

    localparam int TB_DEPTH = 4;
    localparam int CW       = $clog2(TB_DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [2:0]    in_letter;
    logic          in_last;
    logic          in_ready;
    logic          out_valid;
    logic [2:0]    out_letter;
    logic          out_ready;
    logic          busy;
    logic          overflow;
    logic          illegal;
`ifdef ALIGN_FRAMER_LEN_EN
    logic [CW-1:0] out_len;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] g_lets[$];

    align_out_framer #(.DEPTH(TB_DEPTH), .LETTER_WIDTH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_letter  (in_letter),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_letter (out_letter),
        .out_ready  (out_ready),
        .busy       (busy),
        .overflow   (overflow),
        .illegal    (illegal)
`ifdef ALIGN_FRAMER_LEN_EN
        ,
        .out_len    (out_len)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends g_lets (last one with in_last), then collects the framed output.
    // mode: 0 out_ready high, 1 toggling, 2 random. stop_after >= 0 stops
    // after that many accepted words (used before a mid-frame reset).
    task automatic run_frame(input int mode, input int stop_after);
        logic [2:0] s[$];
        logic [2:0] exp[$];
        bit         ovf = 0;
        bit         ill = 0;
        bit         tog = 1;
        bit         rdy;
        int         idx = 0;
        int         cyc = 0;
        foreach (g_lets[i]) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            check("fill_in_ready", in_ready, 1);
            check("fill_out_valid", out_valid, 0);
            check("fill_busy", busy, (s.size() > 0) ? 1 : 0);
            check("fill_overflow", overflow, ovf);
            check("fill_illegal", illegal, ill);
            in_valid  = 1'b1;
            in_letter = g_lets[i];
            in_last   = (i == g_lets.size() - 1);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (g_lets[i] > 3'd4)         ill = 1;
            else if (s.size() < TB_DEPTH) s.push_back(g_lets[i]);
            else                          ovf = 1;
        end
        exp.push_back(3'b111);
        for (int k = s.size() - 1; k >= 0; k--) exp.push_back(s[k]);
        exp.push_back(3'b111);
        check("start_overflow", overflow, ovf);
        check("start_illegal", illegal, ill);
        check("start_busy", busy, 1);
        while (idx < exp.size() && !(stop_after >= 0 && idx >= stop_after)) begin
            if (cyc >= 200) begin
                check("out_timeout", idx, exp.size());
                break;
            end
            check("out_valid", out_valid, 1);
            check("out_letter", out_letter, exp[idx]);
            check("out_in_ready", in_ready, 0);
`ifdef ALIGN_FRAMER_LEN_EN
            check("out_len", out_len, (idx == exp.size() - 1) ? s.size() : 0);
`endif
            case (mode)
                0:       rdy = 1;
                1:       begin rdy = tog; tog = !tog; end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            in_valid  = 1'($urandom_range(0, 1));
            in_letter = 3'($urandom);
            in_last   = 1'($urandom);
            if (rdy) idx++;
            cyc++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        if (stop_after < 0) begin
            check("post_in_ready", in_ready, 1);
            check("post_out_valid", out_valid, 0);
            check("post_out_letter", out_letter, 0);
            check("post_overflow", overflow, 0);
            check("post_illegal", illegal, 0);
            check("post_busy", busy, 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_letter = 3'b000;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_letter", out_letter, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_illegal", illegal, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame, then the same frame under toggling backpressure.
        g_lets = '{3'd3, 3'd2, 3'd1, 3'd0};
        run_frame(0, -1);
        run_frame(1, -1);
        // Overflow: six legal letters into a four-entry stack.
        g_lets = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2};
        run_frame(0, -1);
        // Illegal code in the middle of a frame.
        g_lets = '{3'd1, 3'd6, 3'd2};
        run_frame(2, -1);
        // Single gap letter and illegal-only frame.
        g_lets = '{3'd4};
        run_frame(0, -1);
        g_lets = '{3'd7};
        run_frame(0, -1);

        // Reset after START and two letters have been accepted.
        g_lets = '{3'd3, 3'd2, 3'd1, 3'd0};
        run_frame(0, 3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_out_letter", out_letter, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        g_lets = '{3'd1, 3'd2};
        run_frame(0, -1);

        for (int f = 0; f < 25; f++) begin
            int n;
            n = $urandom_range(1, 7);
            g_lets.delete();
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 9) == 0) g_lets.push_back(3'($urandom_range(5, 7)));
                else                           g_lets.push_back(3'($urandom_range(0, 4)));
            end
            run_frame($urandom_range(0, 2), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
